mdu_issue_ctrl: RTL

//  E-stage issue/interlock controller for the multiply-divide unit (MDU) in the 5-stage MIPS pipeline.

---
 rtl/mdu_pkg.sv | 79 +++++++
 rtl/mdu_issue_ctrl.sv | 109 ++++++++++
 2 files changed

// File: rtl/mdu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : mdu_pkg                                                      |
// | Description : Shared MDU op encoding, MIPS funct codes and op-class        |
// |               helper functions for the multiply-divide unit interface.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package mdu_pkg;

  // MDU operation carried down the pipeline; NONE must stay at zero so that a
  // cleared pipeline register reads as "no MDU work".
  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MADD  = 4'd5,
    OP_MFHI  = 4'd6,
    OP_MFLO  = 4'd7,
    OP_MTHI  = 4'd8,
    OP_MTLO  = 4'd9
  } mdu_op_t;

  // MIPS funct field values presented to the MDU (MADD lives in SPECIAL2).
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1a;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1b;
  localparam logic [5:0] FUNCT_MADD  = 6'h00;
  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;

  // Multi-cycle ops that occupy the MDU after their start pulse.
  function automatic logic is_long(input mdu_op_t op);
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD: return 1'b1;
      default:                                     return 1'b0;
    endcase
  endfunction

  // Any defined MDU op other than NONE touches HI/LO and must respect BUSY.
  function automatic logic is_mdc(input mdu_op_t op);
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD,
      OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  function automatic logic [5:0] op_funct(input mdu_op_t op);
    case (op)
      OP_MULT:  return FUNCT_MULT;
      OP_MULTU: return FUNCT_MULTU;
      OP_DIV:   return FUNCT_DIV;
      OP_DIVU:  return FUNCT_DIVU;
      OP_MADD:  return FUNCT_MADD;
      OP_MFHI:  return FUNCT_MFHI;
      OP_MTHI:  return FUNCT_MTHI;
      OP_MFLO:  return FUNCT_MFLO;
      OP_MTLO:  return FUNCT_MTLO;
      default:  return 6'h00;
    endcase
  endfunction

  // Busy cycles following the start cycle; divides are the slow class.
  function automatic int unsigned op_latency(input mdu_op_t op,
                                             input int unsigned mult_cycles,
                                             input int unsigned div_cycles);
    case (op)
      OP_DIV, OP_DIVU: return div_cycles;
      default:         return mult_cycles;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_issue_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mdu_issue_ctrl                                               |
// | Description : E-stage MDU issue/interlock control. Generates the MDU start |
// |               pulse and funct, stalls D-stage MDU-class instructions while |
// |               the MDU is busy, and flags divergence from MDU BUSY.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mdu_issue_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ex_valid,
  input  logic [3:0] ex_mdu_op,
  input  logic [3:0] id_mdu_op,
  input  logic       mdu_busy,
  output logic       mdu_start,
  output logic [5:0] mdu_funct,
  output logic       stall_d,
  output logic       sync_err
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             prev_issue_q;
  logic             sync_err_q, sync_err_d;

  mdu_op_t ex_op;
  mdu_op_t id_op;
  logic    ex_long;
  logic    issue;
  logic    collide;
  logic    busy_lost;
  logic    busy_unexpected;

  assign ex_op   = mdu_op_t'(ex_mdu_op);
  assign id_op   = mdu_op_t'(id_mdu_op);
  assign ex_long = ex_valid & is_long(ex_op);
  assign issue   = ex_long & (state_q == ST_IDLE);

  // A long op reaching E while busy means the interlock was bypassed; it is
  // dropped rather than issued and reported as a sync error.
  assign collide = ex_long & (state_q == ST_BUSY);

  // Cross-checks against the MDU's own BUSY; skipped on the start cycle since
  // the MDU only latches the start on the closing edge.
  assign busy_lost       = (state_q == ST_BUSY) & ~mdu_busy;
  assign busy_unexpected = (state_q == ST_IDLE) & mdu_busy & ~prev_issue_q;

  // State, latency counter, start history and sticky error register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      prev_issue_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      prev_issue_q <= issue;
      sync_err_q   <= sync_err_d;
    end
  end

  // Next state, counter and outputs; the counter reaching 1 marks the last
  // busy cycle so HI/LO are readable on the cycle after.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sync_err_d = sync_err_q | collide | (~issue & (busy_lost | busy_unexpected));
    mdu_start  = issue;
    mdu_funct  = ex_valid ? op_funct(ex_op) : 6'h00;
    stall_d    = is_mdc(id_op) & (issue | (state_q == ST_BUSY));
    sync_err   = sync_err_q;

    case (state_q)
      ST_IDLE: begin
        if (issue) begin
          state_d = ST_BUSY;
          cnt_d   = CNT_W'(op_latency(ex_op, MULT_CYCLES, DIV_CYCLES));
        end
      end
      ST_BUSY: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule
`default_nettype wire
